// File: rtl/vend_pkg.sv
// vend_pkg: shared definitions for the ticket vending controller.
//  - FSM state encoding (vend_state_e)
//  - coin denominations and fare prices
//  - fare_t (one-hot fare class, or all zero when no fare is latched)
//  - fare_price(): price of a latched fare; coin_legal(): denomination check
package vend_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StCollect  = 3'd1,
    StLock     = 3'd2,
    StDispense = 3'd3,
    StRefund   = 3'd4
  } vend_state_e;

  localparam int unsigned PriceW = 8;

  localparam logic [3:0] COIN_1  = 4'd1;
  localparam logic [3:0] COIN_2  = 4'd2;
  localparam logic [3:0] COIN_5  = 4'd5;
  localparam logic [3:0] COIN_10 = 4'd10;

  localparam logic [PriceW-1:0] PRICE_CHILD = 8'd8;
  localparam logic [PriceW-1:0] PRICE_MEN   = 8'd12;
  localparam logic [PriceW-1:0] PRICE_WOMEN = 8'd15;

  typedef struct packed {
    logic child;
    logic men;
    logic women;
  } fare_t;

  // Returns 0 when no fare is latched; callers test fare validity separately.
  function automatic logic [PriceW-1:0] fare_price(fare_t f);
    logic [PriceW-1:0] p;
    p = '0;
    if (f.child)      p = PRICE_CHILD;
    else if (f.men)   p = PRICE_MEN;
    else if (f.women) p = PRICE_WOMEN;
    return p;
  endfunction

  function automatic logic coin_legal(logic [3:0] v);
    return (v == COIN_1) || (v == COIN_2) || (v == COIN_5) || (v == COIN_10);
  endfunction

endpackage

// File: rtl/vend_coin_acc.sv
// vend_coin_acc: coin accumulator with legality check and saturation guard.
// A coin is accepted only while enable is high, its denomination is legal and the
// new total stays within MAX_CASH; otherwise the sum is unchanged and reject pulses
// for one cycle after the coin. clear empties the accumulator.
// Ports:
//  clk, rst     clock, asynchronous active-high reset
//  clear        empty the accumulator at the next edge
//  enable       coins may be accepted this cycle
//  coin_valid   coin strobe, coin_value its denomination
//  sum          registered accumulated cash
//  reject       registered one-cycle reject strobe
//  accept       combinational: the coin presented this cycle is being added
module vend_coin_acc
  import vend_pkg::*;
#(
  parameter int unsigned CASH_W   = 7,
  parameter int unsigned MAX_CASH = 127
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic              coin_valid,
  input  logic [3:0]        coin_value,
  output logic [CASH_W-1:0] sum,
  output logic              reject,
  output logic              accept
);

  logic [CASH_W-1:0] sum_q, sum_d;
  logic              reject_q, reject_d;
  logic [CASH_W:0]   sum_ext;
  logic              fits;

  // One extra bit so the overflow test cannot itself wrap.
  assign sum_ext = {1'b0, sum_q} + (CASH_W + 1)'(coin_value);
  assign fits    = (32'(sum_ext) <= MAX_CASH);
  assign accept  = coin_valid && enable && coin_legal(coin_value) && fits;

  always_comb begin
    sum_d    = sum_q;
    reject_d = coin_valid && !accept;
    if (clear)       sum_d = '0;
    else if (accept) sum_d = sum_ext[CASH_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q    <= '0;
      reject_q <= 1'b0;
    end else begin
      sum_q    <= sum_d;
      reject_q <= reject_d;
    end
  end

  assign sum    = sum_q;
  assign reject = reject_q;

endmodule

// File: rtl/vend_ticket_ctrl.sv
// vend_ticket_ctrl: sequencing FSM for the ticket vending machine.
// Accumulates coins, latches the fare class and walks the refund datapath through
// LOCK (block_cash), DISPENSE (dispense, refund_en) and REFUND (refund_valid).
// Optional feature macro: VEND_TIMEOUT_EN -- COLLECT auto-cancels after TIMEOUT_CYC
// idle cycles; without it COLLECT waits indefinitely.
// Ports:
//  clk, rst                    clock, asynchronous active-high reset
//  coin_valid, coin_value      coin strobe and denomination (1,2,5,10 legal)
//  sel_child/sel_men/sel_women fare select strobes (priority child > men > women)
//  confirm, cancel             buy / abort strobes
//  cash                        accumulated cash to the refund datapath
//  block_cash                  datapath latches price (LOCK)
//  child/men/women             latched fare class
//  refund_en                   1: refund cash-price, 0: refund all cash
//  dispense, refund_valid      ticket release / refund payout strobes
//  coin_reject, short_cash     coin refused / insufficient cash or no fare
//  busy                        in LOCK, DISPENSE or REFUND
// All outputs are registered.
module vend_ticket_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned CASH_W      = 7,
  parameter int unsigned MAX_CASH    = 127,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coin_valid,
  input  logic [3:0]        coin_value,
  input  logic              sel_child,
  input  logic              sel_men,
  input  logic              sel_women,
  input  logic              confirm,
  input  logic              cancel,
  output logic [CASH_W-1:0] cash,
  output logic              block_cash,
  output logic              child,
  output logic              men,
  output logic              women,
  output logic              refund_en,
  output logic              dispense,
  output logic              refund_valid,
  output logic              coin_reject,
  output logic              short_cash,
  output logic              busy
);

  vend_state_e state_q, state_d;
  fare_t       fare_q, fare_d;
  logic        block_q, block_d;
  logic        disp_q, disp_d;
  logic        rvalid_q, rvalid_d;
  logic        ren_q, ren_d;
  logic        short_q, short_d;
  logic        busy_q, busy_d;

  logic        entry;
  logic        coin_accept;
  logic        sel_any;
  logic        fare_ok;
  logic        cash_ok;
  logic        timeout;

  assign entry   = (state_q == StIdle) || (state_q == StCollect);
  assign sel_any = sel_child || sel_men || sel_women;
  assign fare_ok = fare_q.child || fare_q.men || fare_q.women;
  // Pre-update cash: a coin arriving with confirm is added but not counted here.
  assign cash_ok = fare_ok && (32'(cash) >= 32'(fare_price(fare_q)));

  vend_coin_acc #(
    .CASH_W   (CASH_W),
    .MAX_CASH (MAX_CASH)
  ) u_coin_acc (
    .clk        (clk),
    .rst        (rst),
    .clear      (state_q == StRefund),
    .enable     (entry),
    .coin_valid (coin_valid),
    .coin_value (coin_value),
    .sum        (cash),
    .reject     (coin_reject),
    .accept     (coin_accept)
  );

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            activity;

  // Any coin attempt, selection or confirm counts as customer activity.
  assign activity = coin_valid || sel_any || confirm;
  assign timeout  = (state_q == StCollect) && !activity &&
                    (32'(tmo_q) == TIMEOUT_CYC - 1);

  always_comb begin
    tmo_d = '0;
    if (state_q == StCollect && !activity) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    short_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cancel)                    state_d = StRefund;
        else if (coin_accept || sel_any) state_d = StCollect;
      end
      StCollect: begin
        if (cancel || timeout) begin
          state_d = StRefund;
        end else if (confirm) begin
          if (cash_ok) state_d = StLock;
          else         short_d = 1'b1;
        end
      end
      StLock:     state_d = StDispense;
      StDispense: state_d = StRefund;
      StRefund:   state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    fare_d = fare_q;
    if (state_q == StRefund) begin
      fare_d = '0;
    end else if (entry && sel_any) begin
      fare_d       = '0;
      fare_d.child = sel_child;
      fare_d.men   = !sel_child && sel_men;
      fare_d.women = !sel_child && !sel_men && sel_women;
    end
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    block_d  = (state_d == StLock);
    disp_d   = (state_d == StDispense);
    rvalid_d = (state_d == StRefund);
    ren_d    = (state_d == StDispense) ||
               ((state_d == StRefund) && (state_q == StDispense));
    busy_d   = (state_d == StLock) || (state_d == StDispense) || (state_d == StRefund);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      fare_q   <= '0;
      block_q  <= 1'b0;
      disp_q   <= 1'b0;
      rvalid_q <= 1'b0;
      ren_q    <= 1'b0;
      short_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fare_q   <= fare_d;
      block_q  <= block_d;
      disp_q   <= disp_d;
      rvalid_q <= rvalid_d;
      ren_q    <= ren_d;
      short_q  <= short_d;
      busy_q   <= busy_d;
    end
  end

  assign block_cash   = block_q;
  assign child        = fare_q.child;
  assign men          = fare_q.men;
  assign women        = fare_q.women;
  assign refund_en    = ren_q;
  assign dispense     = disp_q;
  assign refund_valid = rvalid_q;
  assign short_cash   = short_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vend_ticket_ctrl.sv
// Directed bench for vend_ticket_ctrl; expected values are hand-computed.
module tb_vend_ticket_ctrl;

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned Tmo = 16;
`else
  localparam int unsigned Tmo = 1023;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [3:0] coin_value = '0;
  logic       sel_child = 1'b0, sel_men = 1'b0, sel_women = 1'b0;
  logic       confirm = 1'b0, cancel = 1'b0;
  logic [6:0] cash;
  logic       block_cash, child, men, women, refund_en, dispense;
  logic       refund_valid, coin_reject, short_cash, busy;

  int total = 0;
  int bad   = 0;

  vend_ticket_ctrl #(
    .CASH_W      (7),
    .MAX_CASH    (127),
    .TIMEOUT_CYC (Tmo)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .coin_valid   (coin_valid),
    .coin_value   (coin_value),
    .sel_child    (sel_child),
    .sel_men      (sel_men),
    .sel_women    (sel_women),
    .confirm      (confirm),
    .cancel       (cancel),
    .cash         (cash),
    .block_cash   (block_cash),
    .child        (child),
    .men          (men),
    .women        (women),
    .refund_en    (refund_en),
    .dispense     (dispense),
    .refund_valid (refund_valid),
    .coin_reject  (coin_reject),
    .short_cash   (short_cash),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [3:0] v);
    coin_valid = 1'b1;
    coin_value = v;
    cyc();
    coin_valid = 1'b0;
    coin_value = '0;
  endtask

  task automatic pulse_confirm();
    confirm = 1'b1;
    cyc();
    confirm = 1'b0;
  endtask

  task automatic pulse_cancel();
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
  endtask

  // Expects confirm to have just been accepted (now in LOCK).
  task automatic check_purchase(input string tag, input int exp_cash);
    check_eq({tag, " lock block_cash"}, int'(block_cash), 1);
    check_eq({tag, " lock busy"}, int'(busy), 1);
    check_eq({tag, " lock dispense"}, int'(dispense), 0);
    cyc();
    check_eq({tag, " disp dispense"}, int'(dispense), 1);
    check_eq({tag, " disp refund_en"}, int'(refund_en), 1);
    check_eq({tag, " disp block_cash"}, int'(block_cash), 0);
    cyc();
    check_eq({tag, " ref refund_valid"}, int'(refund_valid), 1);
    check_eq({tag, " ref refund_en"}, int'(refund_en), 1);
    check_eq({tag, " ref cash"}, int'(cash), exp_cash);
    cyc();
    check_eq({tag, " idle refund_valid"}, int'(refund_valid), 0);
    check_eq({tag, " idle cash"}, int'(cash), 0);
    check_eq({tag, " idle busy"}, int'(busy), 0);
    check_eq({tag, " idle fare"}, int'({child, men, women}), 0);
  endtask

  initial begin
    int hit;
    #12;
    rst = 1'b0;
    #3;
    cyc();
    check_eq("reset cash", int'(cash), 0);
    check_eq("reset outs", int'({block_cash, child, men, women, refund_en, dispense,
                                 refund_valid, coin_reject, short_cash, busy}), 0);

    // 1: men fare, exact cash
    sel_men = 1'b1; cyc(); sel_men = 1'b0;
    check_eq("t1 men latched", int'({child, men, women}), 3'b010);
    coin(4'd10);
    coin(4'd5);
    check_eq("t1 cash", int'(cash), 15);
    pulse_confirm();
    check_purchase("t1", 15);

    // 2: women, short then enough
    sel_women = 1'b1; cyc(); sel_women = 1'b0;
    coin(4'd10);
    pulse_confirm();
    check_eq("t2 short_cash", int'(short_cash), 1);
    check_eq("t2 short busy", int'(busy), 0);
    cyc();
    check_eq("t2 short one-shot", int'(short_cash), 0);
    coin(4'd5);
    pulse_confirm();
    check_purchase("t2", 15);

    // 3: cancel beats confirm
    coin(4'd10);
    coin(4'd2);
    confirm = 1'b1; cancel = 1'b1;
    cyc();
    confirm = 1'b0; cancel = 1'b0;
    check_eq("t3 refund_valid", int'(refund_valid), 1);
    check_eq("t3 refund_en", int'(refund_en), 0);
    check_eq("t3 cash", int'(cash), 12);
    check_eq("t3 dispense", int'(dispense), 0);
    check_eq("t3 block_cash", int'(block_cash), 0);
    cyc();
    check_eq("t3 idle cash", int'(cash), 0);

    // 4: saturation and illegal coins
    for (int i = 0; i < 12; i++) coin(4'd10);
    check_eq("t4 cash 120", int'(cash), 120);
    check_eq("t4 no reject yet", int'(coin_reject), 0);
    coin(4'd10);
    check_eq("t4 overflow reject", int'(coin_reject), 1);
    check_eq("t4 cash held", int'(cash), 120);
    coin(4'd3);
    check_eq("t4 illegal reject", int'(coin_reject), 1);
    check_eq("t4 cash still", int'(cash), 120);
    coin(4'd5);
    check_eq("t4 125 accepted", int'(coin_reject), 0);
    check_eq("t4 cash 125", int'(cash), 125);
    pulse_cancel();
    check_eq("t4 refund cash", int'(cash), 125);
    cyc();

    // no fare: confirm is short even with cash
    coin(4'd10);
    pulse_confirm();
    check_eq("nofare short_cash", int'(short_cash), 1);
    check_eq("nofare block_cash", int'(block_cash), 0);
    pulse_cancel();
    cyc();

    // 5: priority and reset in LOCK
    sel_child = 1'b1; sel_women = 1'b1; cyc(); sel_child = 1'b0; sel_women = 1'b0;
    check_eq("t5 child priority", int'({child, men, women}), 3'b100);
    sel_men = 1'b1; cyc(); sel_men = 1'b0;
    check_eq("t5 latest wins", int'({child, men, women}), 3'b010);
    sel_child = 1'b1; cyc(); sel_child = 1'b0;
    coin(4'd10);
    pulse_confirm();
    check_eq("t5 lock block_cash", int'(block_cash), 1);
    check_eq("t5 lock child", int'(child), 1);
    // Lock: coin refused, cancel ignored
    coin_valid = 1'b1; coin_value = 4'd1; cancel = 1'b1;
    cyc();
    coin_valid = 1'b0; coin_value = '0; cancel = 1'b0;
    check_eq("t5 lock coin reject", int'(coin_reject), 1);
    check_eq("t5 cancel ignored", int'(dispense), 1);
    pulse_confirm();
    check_eq("t5 refund_valid", int'(refund_valid), 1);
    check_eq("t5 refund_en", int'(refund_en), 1);
    check_eq("t5 cash 10", int'(cash), 10);
    cyc();
    sel_child = 1'b1; cyc(); sel_child = 1'b0;
    coin(4'd10);
    pulse_confirm();
    #2;
    rst = 1'b1;
    #1;
    check_eq("t5 rst block_cash", int'(block_cash), 0);
    check_eq("t5 rst cash", int'(cash), 0);
    check_eq("t5 rst fare", int'({child, men, women}), 0);
    check_eq("t5 rst busy", int'(busy), 0);
    #4;
    rst = 1'b0;
    cyc();
    cyc();
    check_eq("t5 no refund after rst", int'(refund_valid), 0);
    check_eq("t5 no dispense after rst", int'(dispense), 0);

    // 6: timeout
    coin(4'd5);
    hit = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (refund_valid && hit == 0) begin
        hit = i;
        check_eq("t6 refund_en", int'(refund_en), 0);
        check_eq("t6 cash", int'(cash), 5);
      end
    end
`ifdef VEND_TIMEOUT_EN
    check_eq("t6 timeout cycle", hit, 16);
`else
    check_eq("t6 no timeout", hit, 0);
    check_eq("t6 cash kept", int'(cash), 5);
    pulse_cancel();
    cyc();
`endif
    check_eq("t6 final cash", int'(cash), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
